// File: rtl/hazard_issue_ctrl.sv
// Hazard/stall and split-issue controller for the N-wide in-order pipeline.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no mult/div in flight; hazard, split and normal issue apply
// S_MD_BUSY | mult/div result pending; DX/XM/FD/PC frozen until md_ready
//           | or until the busy counter reaches MD_TIMEOUT-1
module hazard_issue_ctrl #(
  parameter int LANES      = 2,
  parameter int AW         = 5,
  parameter int STATUS_REG = 30,
  parameter int MD_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [LANES*AW-1:0] fd_rs,
  input  logic [LANES*AW-1:0] fd_rt,
  input  logic [LANES*AW-1:0] fd_rd,
  input  logic [LANES-1:0]    fd_reg_write,
  input  logic [LANES-1:0]    fd_branch,
  input  logic [LANES-1:0]    fd_jr,
  input  logic [LANES-1:0]    fd_bex,
  input  logic [LANES*AW-1:0] dx_rd,
  input  logic [LANES-1:0]    dx_reg_write,
  input  logic [LANES-1:0]    dx_mem_read,
  input  logic [LANES-1:0]    dx_md_op,
  input  logic [LANES*AW-1:0] xm_rd,
  input  logic [LANES-1:0]    xm_mem_read,
  input  logic                md_ready,
  output logic                pc_write,
  output logic                fd_write,
  output logic                dx_write,
  output logic                xm_write,
  output logic [LANES-1:0]    dx_lane_valid,
  output logic                md_busy,
  output logic                md_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_split_events
`endif
);

  localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MD_TIMEOUT > 0) ? MD_TIMEOUT - 1 : 0);
  localparam logic [AW-1:0] STAT_R = AW'(STATUS_REG);

  typedef enum logic {S_IDLE = 1'b0, S_MD_BUSY = 1'b1} md_state_e;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [LANES-1:0] issued_q, issued_d;
  logic [LANES-1:0] unissued, dep, issue_now, remaining;
  logic             blocked, stall, md_freeze, at_last;

  // Register 0 never matches, which keeps r0 from ever creating a hazard.
  function automatic logic rmatch(input logic [AW-1:0] r, input logic [AW-1:0] a,
                                  input logic [AW-1:0] b);
    return (r != '0) && ((r == a) || (r == b));
  endfunction

  assign unissued = ~issued_q;

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (unissued[i]) begin
          if (dx_mem_read[j] &&
              rmatch(dx_rd[j*AW +: AW], fd_rs[i*AW +: AW], fd_rt[i*AW +: AW]))
            stall = 1'b1;
          if ((fd_branch[i] || fd_jr[i]) && dx_reg_write[j] &&
              rmatch(dx_rd[j*AW +: AW], fd_rs[i*AW +: AW], fd_rd[i*AW +: AW]))
            stall = 1'b1;
          if ((fd_branch[i] || fd_jr[i]) && xm_mem_read[j] &&
              rmatch(xm_rd[j*AW +: AW], fd_rs[i*AW +: AW], fd_rd[i*AW +: AW]))
            stall = 1'b1;
          if (fd_bex[i] &&
              ((dx_reg_write[j] && rmatch(dx_rd[j*AW +: AW], STAT_R, STAT_R)) ||
               (xm_mem_read[j]  && rmatch(xm_rd[j*AW +: AW], STAT_R, STAT_R))))
            stall = 1'b1;
        end
      end
    end
  end

  // Lanes issue in order up to (not including) the first lane that reads an
  // earlier unissued lane's result; the rest wait for a later cycle.
  always_comb begin
    dep       = '0;
    issue_now = '0;
    blocked   = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      for (int m = 0; m < LANES; m++) begin
        if ((m < k) && unissued[k] && unissued[m] && fd_reg_write[m] &&
            (rmatch(fd_rd[m*AW +: AW], fd_rs[k*AW +: AW], fd_rt[k*AW +: AW]) ||
             ((fd_branch[k] || fd_jr[k]) &&
              rmatch(fd_rd[m*AW +: AW], fd_rd[k*AW +: AW], fd_rd[k*AW +: AW]))))
          dep[k] = 1'b1;
      end
    end
    for (int k = 0; k < LANES; k++) begin
      blocked      = blocked | dep[k];
      issue_now[k] = unissued[k] & ~blocked;
    end
  end

  assign remaining = unissued & ~issue_now;
  assign md_freeze = (state_q == S_MD_BUSY) || ((|dx_md_op) && !md_ready);
  assign at_last   = (MD_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    pc_write      = 1'b1;
    fd_write      = 1'b1;
    dx_write      = 1'b1;
    xm_write      = 1'b1;
    dx_lane_valid = '0;
    issued_d      = issued_q;
    if (!reset) begin
      if (md_freeze) begin
        pc_write = 1'b0;
        fd_write = 1'b0;
        dx_write = 1'b0;
        xm_write = 1'b0;
      end else if (stall) begin
        pc_write = 1'b0;
        fd_write = 1'b0;
      end else begin
        dx_lane_valid = issue_now;
        if (|remaining) begin
          pc_write = 1'b0;
          fd_write = 1'b0;
          issued_d = issued_q | issue_now;
        end else begin
          issued_d = '0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|dx_md_op) && !md_ready) begin
          state_d   = S_MD_BUSY;
          cnt_d     = '0;
          timeout_d = (MD_TIMEOUT == 1);
        end
      end
      default: begin
        if (md_ready || at_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          timeout_d = (MD_TIMEOUT != 0) && (cnt_d == CNT_LAST);
        end
      end
    endcase
  end

  // md_timeout is registered so it lines up with the final busy cycle.
  assign md_busy    = (state_q == S_MD_BUSY) && !reset;
  assign md_timeout = timeout_q && !reset;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_split_q, perf_split_d;
  logic        split_start;

  assign split_start = !reset && !md_freeze && !stall && (issued_q == '0) && (|remaining);

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_split_d = perf_split_q;
    if (!fd_write && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
    if (split_start && (perf_split_q != '1))
      perf_split_d = perf_split_q + 32'd1;
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_split_events = perf_split_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      issued_q  <= '0;
`ifdef HAZARD_PERF_CNT_EN
      perf_stall_q <= '0;
      perf_split_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      issued_q  <= issued_d;
`ifdef HAZARD_PERF_CNT_EN
      perf_stall_q <= perf_stall_d;
      perf_split_q <= perf_split_d;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Self-checking bench for hazard_issue_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model.
module tb_hazard_issue_ctrl;
  localparam int LANES      = 2;
  localparam int AW         = 5;
  localparam int STATUS_REG = 30;
  localparam int MD_TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [LANES*AW-1:0] fd_rs, fd_rt, fd_rd, dx_rd, xm_rd;
  logic [LANES-1:0] fd_reg_write, fd_branch, fd_jr, fd_bex;
  logic [LANES-1:0] dx_reg_write, dx_mem_read, dx_md_op, xm_mem_read;
  logic md_ready;
  logic pc_write, fd_write, dx_write, xm_write, md_busy, md_timeout;
  logic [LANES-1:0] dx_lane_valid;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_split_events;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_issue_ctrl #(.LANES(LANES), .AW(AW), .STATUS_REG(STATUS_REG),
                      .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .fd_reg_write(fd_reg_write), .fd_branch(fd_branch), .fd_jr(fd_jr), .fd_bex(fd_bex),
    .dx_rd(dx_rd), .dx_reg_write(dx_reg_write), .dx_mem_read(dx_mem_read),
    .dx_md_op(dx_md_op), .xm_rd(xm_rd), .xm_mem_read(xm_mem_read),
    .md_ready(md_ready),
    .pc_write(pc_write), .fd_write(fd_write), .dx_write(dx_write), .xm_write(xm_write),
    .dx_lane_valid(dx_lane_valid), .md_busy(md_busy), .md_timeout(md_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_split_events(perf_split_events)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [LANES-1:0] m_issued = '0;
  bit  m_busy = 0;
  int  m_cnt  = 0;
  bit  m_to   = 0;
  longint m_perf_stall = 0, m_perf_split = 0;

  bit e_stall, e_freeze, e_left, e_pc, e_dx, e_busy, e_to;
  logic [LANES-1:0] e_valid;
  int cut;
  logic [AW-1:0] rs, rt, rd, d, x, rdm;
  bit br;

  always @(negedge clock) begin
    e_stall = 0;
    for (int i = 0; i < LANES; i++) begin
      if (!m_issued[i]) begin
        rs = fd_rs[i*AW +: AW]; rt = fd_rt[i*AW +: AW]; rd = fd_rd[i*AW +: AW];
        br = fd_branch[i] | fd_jr[i];
        for (int j = 0; j < LANES; j++) begin
          d = dx_rd[j*AW +: AW]; x = xm_rd[j*AW +: AW];
          if (dx_mem_read[j] && d != 0 && (d == rs || d == rt)) e_stall = 1;
          if (br && dx_reg_write[j] && d != 0 && (d == rs || d == rd)) e_stall = 1;
          if (br && xm_mem_read[j] && x != 0 && (x == rs || x == rd)) e_stall = 1;
          if (fd_bex[i] && ((dx_reg_write[j] && d == STATUS_REG) ||
                            (xm_mem_read[j] && x == STATUS_REG))) e_stall = 1;
        end
      end
    end
    e_freeze = m_busy || (dx_md_op != 0 && !md_ready);
    cut = LANES;
    for (int k = 0; k < LANES; k++) begin
      if (!m_issued[k] && cut == LANES) begin
        rs = fd_rs[k*AW +: AW]; rt = fd_rt[k*AW +: AW]; rd = fd_rd[k*AW +: AW];
        br = fd_branch[k] | fd_jr[k];
        for (int m = 0; m < k; m++) begin
          rdm = fd_rd[m*AW +: AW];
          if (!m_issued[m] && fd_reg_write[m] && rdm != 0 &&
              (rdm == rs || rdm == rt || (br && rdm == rd)))
            cut = k;
        end
      end
    end
    e_left = 0;
    e_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!m_issued[k] && k < cut) e_valid[k] = 1'b1;
      if (!m_issued[k] && k >= cut) e_left = 1;
    end

    e_busy = m_busy && !reset;
    e_to   = m_to && !reset;
    if (reset) begin
      e_pc = 1; e_dx = 1; e_valid = '0;
    end else if (e_freeze) begin
      e_pc = 0; e_dx = 0; e_valid = '0;
    end else if (e_stall) begin
      e_pc = 0; e_dx = 1; e_valid = '0;
    end else begin
      e_pc = !e_left; e_dx = 1;
    end

    check("pc_write", 32'(pc_write), 32'(e_pc));
    check("fd_write", 32'(fd_write), 32'(e_pc));
    check("dx_write", 32'(dx_write), 32'(e_dx));
    check("xm_write", 32'(xm_write), 32'(e_dx));
    check("dx_lane_valid", 32'(dx_lane_valid), 32'(e_valid));
    check("md_busy", 32'(md_busy), 32'(e_busy));
    check("md_timeout", 32'(md_timeout), 32'(e_to));
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cycles", perf_stall_cycles, 32'(m_perf_stall));
    check("perf_split_events", perf_split_events, 32'(m_perf_split));
`endif

    if (reset) begin
      m_issued = '0; m_busy = 0; m_cnt = 0; m_to = 0;
      m_perf_stall = 0; m_perf_split = 0;
    end else begin
      if (!e_pc) m_perf_stall++;
      if (!e_freeze && !e_stall && m_issued == '0 && e_left) m_perf_split++;
      if (!e_freeze && !e_stall) m_issued = e_left ? (m_issued | e_valid) : '0;
      m_to = 0;
      if (!m_busy) begin
        if (dx_md_op != 0 && !md_ready) begin
          m_busy = 1; m_cnt = 1; m_to = (m_cnt == MD_TIMEOUT);
        end
      end else if (md_ready || (MD_TIMEOUT != 0 && m_cnt == MD_TIMEOUT)) begin
        m_busy = 0; m_cnt = 0;
      end else begin
        m_cnt++; m_to = (m_cnt == MD_TIMEOUT);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    fd_rs = '0; fd_rt = '0; fd_rd = '0; dx_rd = '0; xm_rd = '0;
    fd_reg_write = '0; fd_branch = '0; fd_jr = '0; fd_bex = '0;
    dx_reg_write = '0; dx_mem_read = '0; dx_md_op = '0; xm_mem_read = '0;
    md_ready = 1'b0;
  endtask

  function automatic logic [AW-1:0] rreg();
    int r = $urandom_range(0, 9);
    return (r >= 8) ? AW'(STATUS_REG) : AW'(r);
  endfunction

  task automatic rand_in();
    for (int l = 0; l < LANES; l++) begin
      fd_rs[l*AW +: AW] = rreg(); fd_rt[l*AW +: AW] = rreg();
      fd_rd[l*AW +: AW] = rreg(); dx_rd[l*AW +: AW] = rreg();
      xm_rd[l*AW +: AW] = rreg();
      fd_reg_write[l] = $urandom_range(0, 1) == 0;
      fd_branch[l]    = $urandom_range(0, 5) == 0;
      fd_jr[l]        = $urandom_range(0, 7) == 0;
      fd_bex[l]       = $urandom_range(0, 7) == 0;
      dx_reg_write[l] = $urandom_range(0, 2) == 0;
      dx_mem_read[l]  = $urandom_range(0, 4) == 0;
      dx_md_op[l]     = $urandom_range(0, 15) == 0;
      xm_mem_read[l]  = $urandom_range(0, 4) == 0;
    end
    md_ready = $urandom_range(0, 3) == 0;
    reset    = $urandom_range(0, 199) == 0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    go(); #1;
    check("rst pc_write", 32'(pc_write), 1);
    check("rst dx_write", 32'(dx_write), 1);
    check("rst valid", 32'(dx_lane_valid), 0);
    check("rst md_busy", 32'(md_busy), 0);

    // load-use: DX lane0 loads r5, FD lane1 reads r5
    go(); reset = 1'b0;
    dx_mem_read = 2'b01; dx_reg_write = 2'b01; dx_rd[0 +: AW] = 5; fd_rs[AW +: AW] = 5;
    #1;
    check("lu fd_write", 32'(fd_write), 0);
    check("lu dx_write", 32'(dx_write), 1);
    check("lu valid", 32'(dx_lane_valid), 0);
    go(); clear_in(); #1;
    check("lu clear fd_write", 32'(fd_write), 1);
    check("lu clear valid", 32'(dx_lane_valid), 2'b11);

    // intra-bundle RAW on r7
    go(); fd_reg_write = 2'b01; fd_rd[0 +: AW] = 7; fd_rs[AW +: AW] = 7; #1;
    check("split c1 valid", 32'(dx_lane_valid), 2'b01);
    check("split c1 fd_write", 32'(fd_write), 0);
    go(); #1;
    check("split c2 valid", 32'(dx_lane_valid), 2'b10);
    check("split c2 fd_write", 32'(fd_write), 1);
    go(); fd_rs[AW +: AW] = 3; #1;
    check("split c3 valid", 32'(dx_lane_valid), 2'b11);
`ifdef HAZARD_PERF_CNT_EN
    check("perf split", perf_split_events, 1);
    check("perf stall", perf_stall_cycles, 2);
`endif

    // bex against XM load of the status register
    go(); clear_in(); fd_bex = 2'b01; xm_mem_read = 2'b10; xm_rd[AW +: AW] = 30; #1;
    check("bex stall", 32'(fd_write), 0);
    go(); xm_rd[AW +: AW] = 29; #1;
    check("bex no stall", 32'(fd_write), 1);
    go(); clear_in(); dx_mem_read = 2'b01; dx_reg_write = 2'b01; #1;
    check("r0 no stall", 32'(fd_write), 1);

    // mult/div freeze released by md_ready
    go(); clear_in(); dx_md_op = 2'b01;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) go();
      if (c == 4) md_ready = 1'b1;
      #1;
      check("md frozen dx_write", 32'(dx_write), 0);
      check("md frozen fd_write", 32'(fd_write), 0);
      check("md busy flag", 32'(md_busy), (c > 0) ? 1 : 0);
    end
    go(); dx_md_op = '0; md_ready = 1'b0; #1;
    check("md release busy", 32'(md_busy), 0);
    check("md release dx_write", 32'(dx_write), 1);

    // timeout with md_ready stuck low
    go(); dx_md_op = 2'b01;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) go();
      #1;
      check("to pulse", 32'(md_timeout), (c == 8) ? 1 : 0);
      check("to busy", 32'(md_busy), (c > 0) ? 1 : 0);
    end
    go(); dx_md_op = '0; #1;
    check("to released busy", 32'(md_busy), 0);
    check("to released pulse", 32'(md_timeout), 0);

    // reset in the middle of MD_BUSY
    go(); dx_md_op = 2'b01;
    go(); go(); #1;
    check("mid busy", 32'(md_busy), 1);
    go(); reset = 1'b1; #1;
    check("rst mid busy", 32'(md_busy), 0);
    check("rst mid busy dx_write", 32'(dx_write), 1);
    go(); reset = 1'b0; dx_md_op = '0; #1;
    check("after rst busy", 32'(md_busy), 0);

    // reset in the middle of a split abandons it
    go(); clear_in(); fd_reg_write = 2'b01; fd_rd[0 +: AW] = 7; fd_rs[AW +: AW] = 7; #1;
    check("split2 c1 valid", 32'(dx_lane_valid), 2'b01);
    go(); reset = 1'b1; #1;
    check("split2 rst valid", 32'(dx_lane_valid), 0);
    go(); reset = 1'b0; #1;
    check("split2 restart valid", 32'(dx_lane_valid), 2'b01);

    for (int n = 0; n < 3000; n++) begin
      go();
      rand_in();
    end
    go(); clear_in(); reset = 1'b0;
    go(); go();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
